// File: rtl/dct_quant_rle_pkg.sv
// Shared types and constants for the DCT quantizer / run-length encoder.
// LEVEL_W lives here because the token layout depends on it.
package dct_quant_rle_pkg;

  localparam int LEVEL_W = 12;
  localparam int RUN_W   = 4;

  localparam logic [7:0] ADDR_COEF  = 8'h00;
  localparam logic [7:0] ADDR_RECIP = 8'h08;
  localparam logic [7:0] ADDR_CTRL  = 8'h10;
  localparam logic [7:0] ADDR_FIFO  = 8'h11;

  localparam int CTRL_START    = 0;
  localparam int CTRL_CLR_DONE = 1;
  localparam int CTRL_CLR_ERR  = 2;

  localparam logic signed [LEVEL_W-1:0] LVL_MAX = {1'b0, {(LEVEL_W-1){1'b1}}};
  localparam logic signed [LEVEL_W-1:0] LVL_MIN = {1'b1, {(LEVEL_W-1){1'b0}}};
  localparam logic [16:0] M_POS_LIM = 17'(2**(LEVEL_W-1) - 1);
  localparam logic [16:0] M_NEG_LIM = 17'(2**(LEVEL_W-1));

  typedef struct packed {
    logic                      eob;
    logic [RUN_W-1:0]          run;
    logic signed [LEVEL_W-1:0] level;
  } token_t;

  typedef enum logic [1:0] {S_IDLE, S_QUANT, S_EOB} state_t;

  // Sign-magnitude multiply by a Q0.16 reciprocal, round half up on the
  // magnitude, then saturate the signed result.
  function automatic logic signed [LEVEL_W-1:0] quantize(
    input logic signed [15:0] coef,
    input logic [15:0]        recip
  );
    logic [15:0] mag;
    logic [32:0] prod;
    logic [16:0] m;
    logic [16:0] neg_m;
    logic signed [LEVEL_W-1:0] q;
    mag   = coef[15] ? 16'(-coef) : 16'(coef);
    prod  = {17'd0, mag} * {17'd0, recip} + 33'h0_0000_8000;
    m     = 17'(prod >> 16);
    neg_m = 17'd0 - m;
    if (!coef[15]) q = (m > M_POS_LIM) ? LVL_MAX : m[LEVEL_W-1:0];
    else           q = (m > M_NEG_LIM) ? LVL_MIN : neg_m[LEVEL_W-1:0];
    return q;
  endfunction

endpackage

// File: rtl/dct_quant_rle_if.sv
// Avalon-MM slave bus bundle for the quantizer/RLE block.
interface dct_quant_rle_if;
  logic [7:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  modport slave  (input address, write, writedata, read, output readdata);
  modport master (output address, write, writedata, read, input readdata);
endinterface

// File: rtl/dct_quant_rle_sync_fifo.sv
// Single-clock FIFO; push is refused while full even if a pop happens the
// same cycle, pop is ignored while empty.
module sync_fifo #(
  parameter  int WIDTH = 17,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dct_quant_rle.sv
// Quantizes 8 DCT coefficients by per-index reciprocals and run-length
// encodes them into a token FIFO the CPU pops over the same slave port.
module dct_quant_rle
  import dct_quant_rle_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] RECIP_RST  = 16'h1000
) (
  input  logic             csi_clk,
  input  logic             rsi_reset_n,
  dct_quant_rle_if.slave   avs_s0,
  output logic             ins_irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t                    state_q, state_d;
  logic [2:0]                idx_q, idx_d;
  logic [RUN_W-1:0]          run_q, run_d;
  logic                      done_q, done_d, err_q, err_d;
  logic signed [15:0]        coef_q [8];
  logic [15:0]               recip_q [8];
  logic [31:0]               readdata_q, rdata_d;
  logic signed [LEVEL_W-1:0] level;
  token_t                    push_tok, head_tok;
  logic                      push, pop, full, empty;
  logic [CNT_W-1:0]          count;
  logic busy, wr_coef, wr_recip, wr_ctrl, start_req, sel_coef, sel_recip;
  logic unused_wdata;

  assign unused_wdata = ^avs_s0.writedata[31:16];

  assign busy      = (state_q != S_IDLE);
  assign sel_coef  = (avs_s0.address[7:3] == ADDR_COEF[7:3]);
  assign sel_recip = (avs_s0.address[7:3] == ADDR_RECIP[7:3]);
  assign wr_coef   = avs_s0.write && sel_coef;
  assign wr_recip  = avs_s0.write && sel_recip;
  assign wr_ctrl   = avs_s0.write && (avs_s0.address == ADDR_CTRL);
  assign start_req = wr_ctrl && avs_s0.writedata[CTRL_START];
  assign pop       = avs_s0.read && (avs_s0.address == ADDR_FIFO) && !empty;

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      for (int i = 0; i < 8; i++) begin
        coef_q[i]  <= '0;
        recip_q[i] <= RECIP_RST;
      end
    end else if (!busy) begin
      if (wr_coef)  coef_q[avs_s0.address[2:0]]  <= avs_s0.writedata[15:0];
      if (wr_recip) recip_q[avs_s0.address[2:0]] <= avs_s0.writedata[15:0];
    end
  end

  assign level = quantize(coef_q[idx_q], recip_q[idx_q]);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    run_d    = run_q;
    push     = 1'b0;
    push_tok = '0;
    done_d   = done_q;
    err_d    = err_q;
    if (wr_ctrl && avs_s0.writedata[CTRL_CLR_DONE]) done_d = 1'b0;
    if (wr_ctrl && avs_s0.writedata[CTRL_CLR_ERR])  err_d  = 1'b0;
    if (busy && (wr_coef || wr_recip || start_req)) err_d  = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d = S_QUANT;
          idx_d   = '0;
          run_d   = '0;
        end
      end
      S_QUANT: begin
        // Whole pipeline holds on a full FIFO, zero or not, so idx only moves with space.
        if (!full) begin
          if (level != '0) begin
            push           = 1'b1;
            push_tok.run   = run_q;
            push_tok.level = level;
            run_d          = '0;
          end else begin
            run_d = run_q + 1'b1;
          end
          if (idx_q == 3'd7) state_d = S_EOB;
          else               idx_d   = idx_q + 1'b1;
        end
      end
      S_EOB: begin
        if (!full) begin
          push         = 1'b1;
          push_tok.eob = 1'b1;
          run_d        = '0;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      run_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  sync_fifo #(.WIDTH($bits(token_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (csi_clk),
    .rst_ni  (rsi_reset_n),
    .push_i  (push),
    .wdata_i (push_tok),
    .pop_i   (pop),
    .rdata_o (head_tok),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    rdata_d = '0;
    if (sel_coef) begin
      rdata_d[15:0] = coef_q[avs_s0.address[2:0]];
    end else if (sel_recip) begin
      rdata_d[15:0] = recip_q[avs_s0.address[2:0]];
    end else if (avs_s0.address == ADDR_CTRL) begin
      rdata_d[31]         = err_q;
      rdata_d[30]         = done_q;
      rdata_d[29]         = busy;
      rdata_d[CNT_W-1:0]  = count;
    end else if (avs_s0.address == ADDR_FIFO && !empty) begin
      rdata_d[31]           = 1'b1;
      rdata_d[30]           = head_tok.eob;
      rdata_d[15:12]        = head_tok.run;
      rdata_d[LEVEL_W-1:0]  = head_tok.level;
    end
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n)     readdata_q <= '0;
    else if (avs_s0.read) readdata_q <= rdata_d;
  end

  assign avs_s0.readdata = readdata_q;
  assign ins_irq         = done_q;

endmodule

// File: tb/tb_dct_quant_rle.sv
// Randomized and directed bench for dct_quant_rle against an arithmetic
// token model and hand-computed constants.
module tb_dct_quant_rle;

  localparam logic [7:0] A_CTRL = 8'h10;
  localparam logic [7:0] A_FIFO = 8'h11;
  localparam logic [31:0] EOB_W = 32'hC000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;
  int n_chk = 0;
  int n_err = 0;
  logic [15:0] cw [8];
  logic [15:0] rw [8];
  logic [31:0] exp_q [$];
  logic [31:0] rd;

  dct_quant_rle_if bus();

  dct_quant_rle #(.FIFO_DEPTH(16), .RECIP_RST(16'h1000)) dut (
    .csi_clk     (clk),
    .rsi_reset_n (rst_n),
    .avs_s0      (bus),
    .ins_irq     (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
    d = bus.readdata;
  endtask

  function automatic logic [31:0] tok(input int run, input longint lvl);
    logic [31:0] w;
    logic [63:0] l;
    l = 64'(lvl);
    w = 32'h8000_0000;
    w[15:12] = 4'(run);
    w[11:0]  = l[11:0];
    return w;
  endfunction

  // Reference: quantize each coefficient with plain integer arithmetic, then RLE.
  function automatic void model_block();
    int run = 0;
    for (int i = 0; i < 8; i++) begin
      longint c, mag, m, lvl;
      c   = longint'($signed(cw[i]));
      mag = (c < 0) ? -c : c;
      m   = (mag * longint'(rw[i]) + 32768) / 65536;
      lvl = (c < 0) ? -m : m;
      if (lvl > 2047)  lvl = 2047;
      if (lvl < -2048) lvl = -2048;
      if (lvl == 0) run++;
      else begin
        exp_q.push_back(tok(run, lvl));
        run = 0;
      end
    end
    exp_q.push_back(EOB_W);
  endfunction

  task automatic load_block();
    for (int i = 0; i < 8; i++) begin
      bus_write(8'(i), {16'h0, cw[i]});
      bus_write(8'(8 + i), {16'h0, rw[i]});
    end
  endtask

  task automatic start_block();
    bus_write(A_CTRL, 32'h2);
    bus_write(A_CTRL, 32'h1);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!irq && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'h0, irq}, 32'h1);
  endtask

  task automatic drain(input string tag);
    logic [31:0] d;
    while (exp_q.size() > 0) begin
      bus_read(A_FIFO, d);
      chk(tag, d, exp_q.pop_front());
    end
    bus_read(A_FIFO, d);
    chk({tag, "_empty"}, d, 32'h0);
  endtask

  task automatic rand_block(input bit dense);
    for (int i = 0; i < 8; i++) begin
      if (dense) begin
        cw[i] = 16'($urandom_range(2000, 30000));
        if ($urandom_range(0, 1) == 1) cw[i] = 16'(-$signed(cw[i]));
        rw[i] = 16'($urandom_range(16'h1000, 16'hFFFF));
      end else begin
        case ($urandom_range(0, 3))
          0: cw[i] = 16'h0;
          1: cw[i] = 16'($signed($urandom_range(0, 80)) - 40);
          default: cw[i] = 16'($urandom);
        endcase
        rw[i] = 16'($urandom);
      end
    end
  endtask

  initial begin
    bus.address = '0; bus.write = 1'b0; bus.writedata = '0; bus.read = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    bus_read(A_CTRL, rd);  chk("rst_status", rd, 32'h0);
    bus_read(8'h08, rd);   chk("rst_recip0", rd, 32'h0000_1000);
    bus_read(A_FIFO, rd);  chk("rst_fifo", rd, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);

    // Directed block with start-to-DONE latency check
    cw = '{16'd160, 16'd0, 16'd0, -16'sd48, 16'd0, 16'd0, 16'd0, 16'd0};
    for (int i = 0; i < 8; i++) rw[i] = 16'h1000;
    load_block();
    start_block();
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("lat_n9", {31'h0, irq}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_n10", {31'h0, irq}, 32'h1);
    bus_read(A_CTRL, rd);  chk("dir_status", rd, 32'h4000_0003);
    exp_q.push_back(32'h8000_000A);
    exp_q.push_back(32'h8000_2FFD);
    exp_q.push_back(EOB_W);
    drain("dir_tok");
    chk("dir_irq", {31'h0, irq}, 32'h1);

    // Rounding: 24/16 = 1.5 -> 2
    cw = '{16'd24, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    load_block(); start_block(); wait_done("rnd_done");
    exp_q.push_back(32'h8000_0002); exp_q.push_back(EOB_W);
    drain("rnd_tok");

    // Negative saturation
    cw[0] = 16'h8000; rw[0] = 16'hFFFF;
    load_block(); start_block(); wait_done("sat_done");
    exp_q.push_back(32'h8000_0800); exp_q.push_back(EOB_W);
    drain("sat_tok");

    // All-zero block -> lone EOB
    for (int i = 0; i < 8; i++) cw[i] = 16'h0;
    load_block(); start_block(); wait_done("zero_done");
    bus_read(A_CTRL, rd);  chk("zero_status", rd, 32'h4000_0001);
    exp_q.push_back(EOB_W);
    drain("zero_tok");

    // Random blocks against the model
    for (int b = 0; b < 8; b++) begin
      rand_block(1'b0);
      load_block(); model_block(); start_block(); wait_done("rnd_blk_done");
      drain("rnd_blk_tok");
    end

    // Two dense blocks without popping: second one stalls on a full FIFO
    rand_block(1'b1);
    load_block(); model_block(); start_block(); wait_done("b2b_done1");
    rand_block(1'b1);
    load_block(); model_block(); start_block();
    repeat (30) @(negedge clk);
    bus_read(A_CTRL, rd);  chk("b2b_full_status", rd, 32'h2000_0010);
    chk("b2b_qlen", 32'(exp_q.size()), 32'd18);
    drain("b2b_tok");
    wait_done("b2b_done2");
    bus_read(A_CTRL, rd);  chk("b2b_end_status", rd, 32'h4000_0000);

    // Writes while busy are dropped and flag ERR
    rand_block(1'b0);
    load_block(); model_block(); start_block();
    bus_write(8'h00, 32'h0000_1234);
    bus_write(A_CTRL, 32'h1);
    wait_done("err_done");
    bus_read(A_CTRL, rd);  chk("err_status", rd, 32'hC000_0000 | 32'(exp_q.size()));
    bus_read(8'h00, rd);   chk("err_coef0", rd, {16'h0, cw[0]});
    drain("err_tok");
    bus_write(A_CTRL, 32'h4);
    bus_read(A_CTRL, rd);  chk("err_clr", rd, 32'h4000_0000);
    bus_write(A_CTRL, 32'h2);
    bus_read(A_CTRL, rd);  chk("done_clr", rd, 32'h0);
    chk("done_clr_irq", {31'h0, irq}, 32'h0);

    // Reset in the middle of QUANT
    rand_block(1'b1);
    load_block(); start_block();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(A_CTRL, rd);  chk("mid_rst_status", rd, 32'h0);
    bus_read(A_FIFO, rd);  chk("mid_rst_fifo", rd, 32'h0);
    bus_read(8'h08, rd);   chk("mid_rst_recip0", rd, 32'h0000_1000);
    bus_read(8'h00, rd);   chk("mid_rst_coef0", rd, 32'h0);
    chk("mid_rst_irq", {31'h0, irq}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
